// File: rtl/mmcm_reconfig_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmcm_reconfig_seq                                            |
// | Description : Request sequencer driving SSTEP/STATE of the MMCM            |
// |               reconfiguration block and supervising its SRDY handshake.    |
// |               Optional macro MMCM_RECONFIG_SEQ_RETRY_EN enables SSTEP      |
// |               reissue after an ack timeout.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmcm_reconfig_seq #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int INIT_STATE     = 0,
  parameter int MAX_RETRY      = 2
) (
  input  logic       CLKIN_DRP,
  input  logic       RST_N,
  input  logic       REQ_VALID,
  input  logic [2:0] REQ_STATE,
  output logic       REQ_READY,
  input  logic       SRDY,
  output logic       SSTEP,
  output logic [2:0] STATE,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] ERR_CODE,
  output logic [2:0] CUR_STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_RDY  = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_LOCK = 3'd4,
    S_FINISH    = 3'd5
  } fsm_t;

  localparam logic [15:0] c_limit = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  c_init  = 3'(INIT_STATE);

  fsm_t        r_fsm;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;
  logic        r_req_ready;
  logic        r_sstep;
  logic [2:0]  r_state;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_err;
  logic [2:0]  r_cur_state;

`ifdef MMCM_RECONFIG_SEQ_RETRY_EN
  localparam logic [7:0] c_max_retry = 8'(MAX_RETRY);
  logic [7:0] r_retry;
`else
  localparam int c_unused_max_retry = MAX_RETRY;
`endif

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  always_ff @(posedge CLKIN_DRP or negedge RST_N) begin
    if (!RST_N) begin
      r_fsm       <= S_IDLE;
      r_cnt       <= 16'd0;
      r_req_ready <= 1'b1;
      r_sstep     <= 1'b0;
      r_state     <= c_init;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 2'd0;
      r_cur_state <= c_init;
`ifdef MMCM_RECONFIG_SEQ_RETRY_EN
      r_retry     <= 8'd0;
`endif
    end else begin
      r_sstep <= 1'b0;
      r_done  <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (REQ_VALID && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_err       <= 2'd0;
`ifdef MMCM_RECONFIG_SEQ_RETRY_EN
            r_retry     <= 8'd0;
`endif
            if (REQ_STATE <= 3'd4) begin
              r_state <= REQ_STATE;
              r_busy  <= 1'b1;
              r_fsm   <= S_WAIT_RDY;
            end else begin
              // Invalid target: report straight away, STATE keeps last value
              r_err  <= 2'd1;
              r_done <= 1'b1;
              r_fsm  <= S_FINISH;
            end
          end
        end
        S_WAIT_RDY: begin
          if (SRDY) begin
            r_sstep <= 1'b1;
            r_fsm   <= S_STEP;
          end
        end
        S_STEP: begin
          r_cnt <= 16'd0;
          r_fsm <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // SRDY falling takes priority over a coincident timeout
          if (!SRDY) begin
            r_cnt <= 16'd0;
            r_fsm <= S_WAIT_LOCK;
          end else if (r_cnt == c_limit) begin
`ifdef MMCM_RECONFIG_SEQ_RETRY_EN
            if (r_retry < c_max_retry) begin
              r_retry <= r_retry + 8'd1;
              r_fsm   <= S_WAIT_RDY;
            end else begin
              r_err  <= 2'd2;
              r_done <= 1'b1;
              r_busy <= 1'b0;
              r_fsm  <= S_FINISH;
            end
`else
            r_err  <= 2'd2;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_fsm  <= S_FINISH;
`endif
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_LOCK: begin
          if (SRDY) begin
            r_cur_state <= r_state;
            r_err       <= 2'd0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_fsm       <= S_FINISH;
          end else if (r_cnt == c_limit) begin
            r_err  <= 2'd3;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_fsm  <= S_FINISH;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_FINISH: begin
          r_req_ready <= 1'b1;
          r_fsm       <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_fsm       <= S_IDLE;
        end
      endcase
    end
  end

  assign REQ_READY = r_req_ready;
  assign SSTEP     = r_sstep;
  assign STATE     = r_state;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR_CODE  = r_err;
  assign CUR_STATE = r_cur_state;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_reconfig_seq.sv
`default_nettype none
// Testbench for mmcm_reconfig_seq: randomized requests against a timeline model,
// with a scoreboard checked on every DONE pulse.
module tb_mmcm_reconfig_seq;

  localparam int TMO  = 16;
  localparam int INIT = 2;
  localparam int MAXR = 2;
`ifdef MMCM_RECONFIG_SEQ_RETRY_EN
  localparam int RETRIES = MAXR;
`else
  localparam int RETRIES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_state = 3'd0;
  logic       srdy;
  logic       req_ready;
  logic       sstep;
  logic [2:0] state;
  logic       busy;
  logic       done;
  logic [1:0] err_code;
  logic [2:0] cur_state;

  always #5 clk = ~clk;

  mmcm_reconfig_seq #(
    .TIMEOUT_CYCLES(TMO),
    .INIT_STATE    (INIT),
    .MAX_RETRY     (MAXR)
  ) dut (
    .CLKIN_DRP(clk),
    .RST_N    (rst_n),
    .REQ_VALID(req_valid),
    .REQ_STATE(req_state),
    .REQ_READY(req_ready),
    .SRDY     (srdy),
    .SSTEP    (sstep),
    .STATE    (state),
    .BUSY     (busy),
    .DONE     (done),
    .ERR_CODE (err_code),
    .CUR_STATE(cur_state)
  );

  typedef struct {
    int err;
    int cur;
    int st;
    int nstep;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cur;
  int   m_state;
  int   ds_ack_dly  = 1;
  int   ds_lock_dly = 1;
  bit   ds_hold_low = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Downstream model: SRDY drops ack_dly cycles after SSTEP, returns lock_dly later
  initial begin
    srdy = 1'b1;
    forever begin
      @(negedge clk);
      if (ds_hold_low) begin
        srdy = 1'b0;
      end else if (sstep === 1'b1 && ds_ack_dly != 0) begin
        repeat (ds_ack_dly) @(negedge clk);
        srdy = 1'b0;
        repeat (ds_lock_dly) @(negedge clk);
        srdy = 1'b1;
      end else begin
        srdy = 1'b1;
      end
    end
  end

  // Monitor: accept/SSTEP tracking and scoreboard comparison at each DONE
  initial begin
    int   cyc;
    int   acc_cyc;
    int   nstep;
    bit   prev_srdy;
    bit   prev_sstep;
    bit   want_ready;
    exp_t e;
    cyc = 0; acc_cyc = 0; nstep = 0;
    prev_srdy = 1'b1; prev_sstep = 1'b0; want_ready = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        nstep = 0; want_ready = 1'b0; prev_sstep = 1'b0; prev_srdy = srdy;
        continue;
      end
      if (want_ready) begin
        chk("req_ready_after_done", int'(req_ready), 1);
        want_ready = 1'b0;
      end
      if (sstep) begin
        nstep++;
        chk("sstep_needs_srdy", int'(prev_srdy & srdy), 1);
        chk("sstep_single_cycle", int'(prev_sstep), 0);
        if (sb.size() != 0) chk("state_at_sstep", int'(state), sb[0].st);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_without_request: DONE seen with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("err_code", int'(err_code), e.err);
          chk("cur_state", int'(cur_state), e.cur);
          chk("state", int'(state), e.st);
          chk("sstep_count", nstep, e.nstep);
          chk("busy_at_done", int'(busy), 0);
          if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
          want_ready = 1'b1;
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        nstep   = 0;
      end
      prev_srdy  = srdy;
      prev_sstep = sstep;
    end
  end

  // Issue one request; the expected outcome comes from the downstream timeline
  task automatic issue(input int r, input int ack, input int lock, input bit known_lat);
    int   n;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) bound_fail("wait_req_ready");
    ds_ack_dly  = ack;
    ds_lock_dly = lock;
    if (r > 4) begin
      e = '{1, m_cur, m_state, 0, 1};
    end else begin
      m_state = r;
      if (ack == 0)
        e = '{2, m_cur, r, 1 + RETRIES, TMO + 3 + (TMO + 2) * RETRIES};
      else if (lock <= TMO) begin
        m_cur = r;
        e = '{0, r, r, 1, ack + lock + 3};
      end else
        e = '{3, m_cur, r, 1, ack + TMO + 3};
    end
    if (!known_lat) e.lat = -1;
    sb.push_back(e);
    req_state = 3'(r);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || srdy !== 1'b1 || busy !== 1'b0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) bound_fail("wait_idle");
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sstep"}, int'(sstep), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_req_ready"}, int'(req_ready), 1);
    chk({tag, "_err"}, int'(err_code), 0);
    chk({tag, "_state"}, int'(state), INIT);
    chk({tag, "_cur_state"}, int'(cur_state), INIT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int ack;
    int lock;
    m_cur   = INIT;
    m_state = INIT;
    rst_n   = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Directed: nominal, minimum latency, invalid, ack/lock timeouts, limit boundaries
    issue(3, 1, 10, 1'b1); wait_idle();
    issue(3, 1, 1, 1'b1);  wait_idle();
    issue(6, 1, 1, 1'b1);  wait_idle();
    issue(1, 0, 0, 1'b1);  wait_idle();
    issue(4, 1, 40, 1'b1); wait_idle();
    issue(0, TMO, TMO, 1'b1); wait_idle();
    issue(2, 3, TMO + 1, 1'b1); wait_idle();

    // SRDY held low at request time: no SSTEP until it rises
    ds_hold_low = 1'b1;
    step(); step();
    issue(1, 2, 5, 1'b0);
    for (int i = 0; i < 50; i++) begin
      chk("blocked_sstep", int'(sstep), 0);
      chk("blocked_busy", int'(busy), 1);
      step();
    end
    ds_hold_low = 1'b0;
    step();
    chk("sstep_before_rise_seen", int'(sstep), 0);
    step();
    chk("sstep_after_rise", int'(sstep), 1);
    wait_idle();

    // Asynchronous reset in WAIT_LOCK
    issue(4, 1, 100, 1'b0);
    repeat (4) step();
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midop_reset");
    sb.delete();
    m_cur   = INIT;
    m_state = INIT;
    step(); step();
    rst_n = 1'b1;
    wait_idle();
    issue(4, 2, 3, 1'b1); wait_idle();

    // Randomized requests
    for (int i = 0; i < 25; i++) begin
      r    = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      ack  = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TMO));
      lock = int'($urandom_range(1, TMO + 4));
      issue(r, ack, lock, 1'b1);
      wait_idle();
    end

    chk("scoreboard_drained", sb.size(), 0);
    chk("final_cur_state", int'(cur_state), m_cur);
    chk("final_state", int'(state), m_state);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
